// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One conversion takes BIN_WIDTH shift steps plus one result-load step; the result is held
// stable until the next conversion completes.
// Optional leading-zero blanking mask is enabled by defining BIN2BCD_BLANK_EN; otherwise
// blank_o is tied to zero.
module bin2bcd_seq #(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned DIGITS    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*DIGITS-1:0]  bcd_o,
    output logic                 ovf_o,
    output logic [DIGITS-1:0]    blank_o
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned ScrW = BcdW + BIN_WIDTH;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    // Counter value during the final shift step.
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    // Scratch register: BCD field in the upper bits, binary field in the lower bits.
    logic [ScrW-1:0] scr_q;
    logic [ScrW-1:0] scr_adj;
    logic [CntW-1:0] cnt_q;
    logic            sticky_q;
    logic [BcdW-1:0] bcd_q;
    logic            ovf_q;
    logic            done_q;
    logic [BcdW-1:0] bcd_field;

    assign bcd_field = scr_q[ScrW-1 -: BcdW];

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT for BIN_WIDTH steps, DONE for one edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Add-3 correction: every BCD nibble >= 5 is bumped before the shift.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scr_q[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                scr_adj[BIN_WIDTH + 4*i +: 4] = scr_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: load on accepted start, shift-and-accumulate overflow in SHIFT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scr_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        scr_q    <= {{BcdW{1'b0}}, bin_i};
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                    end
                end
                StShift: begin
                    scr_q    <= {scr_adj[ScrW-2:0], 1'b0};
                    // A carry out of the top digit means the value exceeds 10^DIGITS-1.
                    sticky_q <= sticky_q | scr_adj[ScrW-1];
                    cnt_q    <= cnt_q + CntW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers: updated only on the DONE edge; done pulses for exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            if (state_q == StDone) begin
                bcd_q <= bcd_field;
                ovf_q <= sticky_q;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    // Reset result is all zeros, so every digit but the units digit is blanked.
    localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;
    logic              upper_zero;

    // Leading-zero mask: digit i blanks when it and every higher digit are zero (i >= 1).
    always_comb begin
        blank_d    = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (bcd_field[4*i +: 4] == 4'd0);
            blank_d[i] = upper_zero;
        end
    end

    // Blank mask register, loaded together with the BCD result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blank_q <= BlankRst;
        end else if (state_q == StDone) begin
            blank_q <= blank_d;
        end
    end
`endif

    // Output logic: busy covers SHIFT and DONE; results come straight from registers.
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = done_q;
        bcd_o  = bcd_q;
        ovf_o  = ovf_q;
`ifdef BIN2BCD_BLANK_EN
        blank_o = blank_q;
`else
        blank_o = '0;
`endif
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a default 3-digit instance and a 2-digit instance share
// the same stimulus. A cycle-counting decimal model is compared every cycle; directed literal
// expectations pin the model.
module tb_bin2bcd_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin   = 8'd0;

    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [2:0] BlkZero = 3'b110;
    localparam logic [2:0] Blk99   = 3'b100;
`else
    localparam logic [2:0] BlkZero = 3'b000;
    localparam logic [2:0] Blk99   = 3'b000;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .ovf_o   (ovf),
        .blank_o (blank)
    );

    bin2bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy2),
        .done_o  (done2),
        .bcd_o   (bcd2),
        .ovf_o   (ovf2),
        .blank_o (blank2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int ndig(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int pow10(input int d);
        return (d == 3) ? 1000 : 100;
    endfunction

    // Decimal digits of v mod 10^d, packed one per nibble.
    function automatic logic [11:0] dec_bcd(input int v, input int d);
        logic [11:0] r;
        int m;
        r = '0;
        m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] lead_blank(input logic [11:0] b, input int d);
        logic [2:0] r;
        r = '0;
        for (int i = 1; i < d; i++) begin
            r[i] = ((b >> (4*i)) == 12'd0);
        end
`ifndef BIN2BCD_BLANK_EN
        r = '0;
`endif
        return r;
    endfunction

    // Model: a conversion takes 9 cycles from the accepting edge; results appear with done.
    int          m_rem [2];
    int          m_val [2];
    logic [11:0] e_bcd [2];
    logic        e_ovf [2];
    logic        e_done[2];
    logic [2:0]  e_blank[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_rem[k]   <= 0;
                m_val[k]   <= 0;
                e_bcd[k]   <= '0;
                e_ovf[k]   <= 1'b0;
                e_done[k]  <= 1'b0;
                e_blank[k] <= lead_blank(12'h000, ndig(k));
            end else if (m_rem[k] == 0) begin
                e_done[k] <= 1'b0;
                if (start) begin
                    m_val[k] <= int'(bin);
                    m_rem[k] <= 9;
                end
            end else begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 1) begin
                    e_bcd[k]   <= dec_bcd(m_val[k], ndig(k));
                    e_ovf[k]   <= (m_val[k] >= pow10(ndig(k)));
                    e_blank[k] <= lead_blank(dec_bcd(m_val[k], ndig(k)), ndig(k));
                    e_done[k]  <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   32'(busy),   32'(m_rem[0] != 0));
            check("done",   32'(done),   32'(e_done[0]));
            check("bcd",    32'(bcd),    32'(e_bcd[0]));
            check("ovf",    32'(ovf),    32'(e_ovf[0]));
            check("blank",  32'(blank),  32'(e_blank[0]));
            check("busy2",  32'(busy2),  32'(m_rem[1] != 0));
            check("done2",  32'(done2),  32'(e_done[1]));
            check("bcd2",   32'(bcd2),   32'(e_bcd[1][7:0]));
            check("ovf2",   32'(ovf2),   32'(e_ovf[1]));
            check("blank2", 32'(blank2), 32'(e_blank[1][1:0]));
        end
    end

    // Start one conversion and wait for done; n = edges from start to done, b = busy cycles.
    task automatic do_conv(input logic [7:0] v, output int n, output int b);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        b = busy ? 1 : 0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) b++;
        end
        if (!done) n = 99;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b, pulses;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_bcd",   32'(bcd),   32'h000);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_blank", 32'(blank), 32'(BlkZero));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 255: latency and busy width
        do_conv(8'd255, n, b);
        check("lat255",  32'(n),    32'd9);
        check("busy255", 32'(b),    32'd9);
        check("done255", 32'(done), 32'd1);
        check("bcd255",  32'(bcd),  32'h255);
        check("ovf255",  32'(ovf),  32'd0);
        check("bcd2_255", 32'(bcd2), 32'h55);
        check("ovf2_255", 32'(ovf2), 32'd1);

        // 0 then 7 back-to-back, second start in the done cycle
        do_conv(8'd0, n, b);
        check("bcd0",   32'(bcd),   32'h000);
        check("blank0", 32'(blank), 32'(BlkZero));
        do_conv(8'd7, n, b);
        check("lat7",   32'(n),     32'd9);
        check("bcd7",   32'(bcd),   32'h007);
        check("blank7", 32'(blank), 32'(BlkZero));

        // 99 with bin changed and start held high while busy
        bin   = 8'd99;
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = 8'd200;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("pulses99", 32'(pulses), 32'd1);
        check("bcd99",    32'(bcd),    32'h099);
        check("blank99",  32'(blank),  32'(Blk99));
        check("bcd2_99",  32'(bcd2),   32'h99);
        check("ovf2_99",  32'(ovf2),   32'd0);

        // 2-digit overflow then recovery
        do_conv(8'd200, n, b);
        check("bcd2_200", 32'(bcd2), 32'h00);
        check("ovf2_200", 32'(ovf2), 32'd1);
        check("bcd200",   32'(bcd),  32'h200);
        do_conv(8'd42, n, b);
        check("bcd2_42",  32'(bcd2), 32'h42);
        check("ovf2_42",  32'(ovf2), 32'd0);

        // Reset during the 4th shift cycle aborts the conversion
        bin   = 8'd128;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_bcd",   32'(bcd),   32'h000);
        check("abort_bcd2",  32'(bcd2),  32'h00);
        check("abort_blank", 32'(blank), 32'(BlkZero));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || done2) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        do_conv(8'd128, n, b);
        check("bcd128",   32'(bcd),  32'h128);
        check("bcd2_128", 32'(bcd2), 32'h28);

        // Full sweep of the input range
        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), n, b);
            check("sweep_lat", 32'(n),   32'd9);
            check("sweep_bcd", 32'(bcd), 32'(dec_bcd(v, 3)));
            check("sweep_ovf", 32'(ovf), 32'd0);
            for (int i = 0; i < 3; i++) begin
                check("sweep_nib", 32'(bcd[4*i +: 4] > 4'd9), 32'd0);
            end
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Produces packed BCD digits that feed the 4-bit BCD inputs of the 7-segment decoders, one decoder per digit. The score and level counters of the Genius game are displayed through it.
- Start/busy/done handshake. One conversion at a time. Result is held stable until the next conversion completes.

Parameters:
- BIN_WIDTH, 8, width of binary input; equals number of shift cycles per conversion
- DIGITS, 3, number of BCD output digits (4 bits each)

Ports:
- clk_i  input  1  system clock, rising edge
- rst_n_i  input  1  asynchronous reset, active-low
- start_i  input  1  conversion request; sampled only in IDLE
- bin_i  input  BIN_WIDTH  unsigned binary value; captured on the accepted start edge
- busy_o  output  1  high while converting
- done_o  output  1  one-cycle pulse when bcd_o is updated
- bcd_o  output  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0]
- ovf_o  output  1  value exceeded 10^DIGITS-1; updated together with bcd_o
- blank_o  output  DIGITS  leading-zero mask, one bit per digit (see Optional Feature)

Behaviour:
- Reset (rst_n_i low, asynchronous): state=IDLE, busy_o=0, done_o=0, bcd_o=0, ovf_o=0, internal shift register and counter cleared.
- blank_o reset value: all ones except bit 0 when the feature is enabled; 0 otherwise.
- Internal state:
  - scratch register: 4*DIGITS BCD bits plus BIN_WIDTH binary bits
  - shift counter: $clog2(BIN_WIDTH+1) bits
  - sticky overflow bit
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start_i=1: binary field <= bin_i; BCD field, counter and sticky overflow <= 0; busy_o <= 1; go to SHIFT.
  - start_i=0: hold. done_o <= 0.
- SHIFT (one step per edge, exactly BIN_WIDTH steps):
  - Every BCD nibble >= 5 gets +3 (combinational).
  - Then the whole scratch register shifts left by 1.
  - The bit shifted out of the top digit is ORed into sticky overflow.
  - Counter increments. When the counter reaches BIN_WIDTH after this step, go to DONE.
- DONE (one edge):
  - bcd_o <= BCD field; ovf_o <= sticky overflow; blank_o updated.
  - done_o <= 1, busy_o <= 0; go to IDLE.
  - Next edge: done_o <= 0.
- Latency: start accepted at edge E0. busy_o is high after E0 through E(BIN_WIDTH+1). bcd_o and done_o become valid after E(BIN_WIDTH+1). Total BIN_WIDTH+1 cycles from start to done.
- start_i while busy (SHIFT/DONE): ignored, no queueing.
- start_i in the cycle done_o=1 (state is IDLE): accepted; back-to-back conversions, one every BIN_WIDTH+2 cycles.
- bin_i changes after the accepting edge have no effect on the conversion in flight.
- Overflow: bcd_o = bin_i mod 10^DIGITS, ovf_o=1. Every output nibble is always in 0..9.
- Reset mid-conversion: abort immediately to reset values. No done_o pulse. Previous result is lost.
- bcd_o, ovf_o and blank_o change only on the done edge or on reset.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - blank_o[i]=1 when digit i and all higher digits of the new result are zero, for i>=1.
  - blank_o[0] is always 0.
  - blank_o is registered with bcd_o, so the display layer can switch off leading 7-segment digits.
- Undefined: blank_o is tied to all zeros. Port list unchanged.

Test Plan:
- Defaults, bin_i=255, one start pulse -> done_o pulses exactly 9 cycles after the start edge; bcd_o=12'h255; ovf_o=0; busy_o high for 9 cycles.
- bin_i=0 then bin_i=7 back-to-back, second start in the done cycle -> bcd_o=12'h000, then 12'h007. With BIN2BCD_BLANK_EN both give blank_o=3'b110.
- bin_i=99, start; bin_i changed to 200 and start_i held high during busy -> exactly one done pulse; bcd_o=12'h099; blank_o=3'b100 with feature enabled.
- DIGITS=2, bin_i=200 -> bcd_o=8'h00, ovf_o=1. Next conversion with bin_i=42 -> bcd_o=8'h42, ovf_o=0.
- Start with bin_i=128, rst_n_i low for 1 cycle at the 4th shift cycle -> all outputs at reset values; no done_o pulse. A later start with bin_i=128 -> bcd_o=12'h128.
- Sweep bin_i 0..255 -> every bcd_o equals the decimal value, all nibbles <= 9, ovf_o=0.
